// File: rtl/lmsm_sequencer_if.sv
// Handshake bundle between ID-stage decode, the LM/SM sequencer and the EX/MEM stage.
// The slave modport is the sequencer side. The master modport is the driver and consumer side.
interface lmsm_sequencer_if #(
    parameter int MASK_W = 8,
    parameter int ADDR_W = 16
);
    logic              start;
    logic              is_lm;
    logic [MASK_W-1:0] imm_mask;
    logic [ADDR_W-1:0] base_addr;
    logic              flush;
    logic              mem_ready;

    logic              busy;
    logic              stall;
    logic              uop_valid;
    logic              uop_lm;
    logic              uop_sm;
    logic [2:0]        uop_rd;
    logic [ADDR_W-1:0] uop_addr;
    logic              done;

    modport master (
        output start, is_lm, imm_mask, base_addr, flush, mem_ready,
        input  busy, stall, uop_valid, uop_lm, uop_sm, uop_rd, uop_addr, done
    );

    modport slave (
        input  start, is_lm, imm_mask, base_addr, flush, mem_ready,
        output busy, stall, uop_valid, uop_lm, uop_sm, uop_rd, uop_addr, done
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Breaks an LM/SM instruction into one micro-op per set mask bit, in ascending register order,
// at consecutive word addresses. The upstream pipeline stalls until the sequence completes.
module lmsm_sequencer #(
    parameter int MASK_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic                clock,
    input  logic                clear,
    lmsm_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state;
    logic [MASK_W-1:0] mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic              kind_q;

    logic [MASK_W-1:0] mask_next;
    logic [2:0]        low_idx;
    logic              found;
    logic              run;

    // Clearing the lowest set bit of the mask gives the remaining registers after an acceptance.
    assign mask_next = mask_q & (mask_q - MASK_W'(1));

    always_comb begin
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (mask_q[i] && !found) begin
                low_idx = 3'(i);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            mask_q <= '0;
            addr_q <= '0;
            kind_q <= 1'b0;
        end else if (bus.flush) begin
            state  <= IDLE;
            mask_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask_q <= bus.imm_mask;
                        addr_q <= bus.base_addr;
                        kind_q <= bus.is_lm;
                        state  <= (|bus.imm_mask) ? RUN : FINISH;
                    end
                end
                RUN: begin
                    if (bus.mem_ready) begin
                        mask_q <= mask_next;
                        addr_q <= addr_q + ADDR_W'(1);
                        if (mask_next == '0)
                            state <= FINISH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign run           = (state == RUN);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FINISH);
    assign bus.uop_valid = run & ~bus.flush;
    assign bus.uop_lm    = bus.uop_valid & kind_q;
    assign bus.uop_sm    = bus.uop_valid & ~kind_q;
    assign bus.uop_rd    = low_idx;
    assign bus.uop_addr  = addr_q;
    // The stall path is combinational from start. Gating it with clear keeps it low during reset.
    assign bus.stall     = clear & (run | ((state == IDLE) & bus.start & ~bus.flush));

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 The block SHALL have parameter MASK_W, default 8, meaning the register-mask width and register count (one bit per register).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning the word-address width.
REQ-003 The block SHALL have port clock, input, 1, the single system clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port clear, input, 1, reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, a decoded LM/SM instruction is presented this cycle.
REQ-006 The block SHALL have port is_lm, input, 1: 1 = LM (load multiple), 0 = SM (store multiple); sampled with start.
REQ-007 The block SHALL have port imm_mask, input, MASK_W: bit i set means register Ri is transferred; sampled with start.
REQ-008 The block SHALL have port base_addr, input, ADDR_W, the first memory word address; sampled with start.
REQ-009 The block SHALL have port flush, input, 1, synchronous squash from branch resolution.
REQ-010 The block SHALL have port mem_ready, input, 1: the EX/MEM stage accepts the current micro-op this cycle.
REQ-011 The block SHALL have port busy, output, 1: the sequencer is not IDLE.
REQ-012 The block SHALL have port stall, output, 1: hold upstream pipeline registers (drives their enable low).
REQ-013 The block SHALL have port uop_valid, output, 1: a micro-op is presented to EX/MEM.
REQ-014 The block SHALL have ports uop_lm and uop_sm, output, 1 each: the micro-op kind, mutually exclusive, both gated by uop_valid.
REQ-015 The block SHALL have port uop_rd, output, 3, the register index of the current micro-op.
REQ-016 The block SHALL have port uop_addr, output, ADDR_W, the memory word address of the current micro-op.
REQ-017 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-019 In IDLE, when start=1 and flush=0, the block SHALL latch imm_mask, base_addr and is_lm; the next state SHALL be RUN if the mask is nonzero, else FINISH.
REQ-020 A start asserted while the FSM is in RUN or FINISH SHALL be ignored.
REQ-021 In RUN, uop_valid SHALL be 1 and flush SHALL be 0; uop_rd SHALL be the index of the lowest set bit of the remaining mask, so registers are processed in ascending order.
REQ-022 In RUN, uop_addr SHALL equal the latched base_addr plus the number of micro-ops already accepted, modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
REQ-023 In RUN, when mem_ready=1 the block SHALL clear that mask bit and increment the address by 1; if the remaining mask becomes zero, the next state SHALL be FINISH.
REQ-024 In RUN, when mem_ready=0, uop_rd, uop_addr and the uop kind SHALL hold stable and uop_valid SHALL stay 1.
REQ-025 In FINISH, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-026 stall SHALL equal (state==RUN) OR (state==IDLE AND start AND NOT flush), combinationally; stall SHALL be 0 in FINISH.
REQ-027 busy SHALL be 1 in RUN and FINISH, else 0.
REQ-028 flush=1 in any state SHALL force the next state to IDLE, clear the latched mask, and gate uop_valid to 0 in the same cycle.
REQ-029 When flush and mem_ready coincide, flush SHALL have priority: no bit is consumed and done is not pulsed.
REQ-030 Latency from an accepted start SHALL be N+1 cycles to done for N set mask bits, with mem_ready held at 1; a zero mask SHALL give done one cycle after start.

Reset
REQ-031 While clear=0, the state SHALL be IDLE and the latched mask, address and kind SHALL be 0, asynchronously.
REQ-032 While clear=0, all outputs SHALL be 0, including busy, stall, uop_valid, uop_lm, uop_sm, uop_rd, uop_addr and done.
REQ-033 Reset asserted mid-RUN SHALL abandon the sequence with no done pulse; the first start after clear returns to 1 SHALL be accepted normally.

Verification
REQ-034 The bench SHALL cover: LM, mask 0x05, base 0x0010, mem_ready=1 -> C0 stall=1; C1 uop (R0, 0x0010, uop_lm=1); C2 uop (R2, 0x0011); C3 done=1, stall=0, busy=1; C4 busy=0.
REQ-035 The bench SHALL cover: SM, mask 0x80, base 0x0200, mem_ready low for 3 RUN cycles -> uop (R7, 0x0200, uop_sm=1) held 4 cycles; done one cycle after mem_ready rises.
REQ-036 The bench SHALL cover: mask 0x00 -> uop_valid never 1; done=1 at C1; stall=1 only in C0.
REQ-037 The bench SHALL cover: mask 0x03, base 0xFFFF -> uop_addr 0xFFFF for R0, then 0x0000 for R1.
REQ-038 The bench SHALL cover: mask 0xFF, flush after the R0 acceptance -> uop_valid=0 in the flush cycle; IDLE next cycle; no done; a new start is accepted the cycle after.
REQ-039 The bench SHALL cover: clear=0 asynchronously mid-RUN -> all outputs 0 before the next edge; no done after release.
